// File: rtl/ir_encoder.sv
// ir_encoder: pulse-distance IR frame transmitter.
// Sends a leader, MESSAGE_LENGTH data bits LSB first, a stop mark and an
// inter-frame gap. Optional build macro IR_CARRIER_EN: when defined, marks
// are gated by a square-wave carrier; otherwise signal_out is the raw
// mark envelope.
module ir_encoder #(
  parameter int MESSAGE_LENGTH      = 5,
  parameter int BIT_CYCLES          = 56250,
  parameter int ONE_SPACE_CYCLES    = 168750,
  parameter int LEAD_MARK_CYCLES    = 900000,
  parameter int LEAD_SPACE_CYCLES   = 450000,
  parameter int GAP_CYCLES          = 2000000,
  parameter int CARRIER_HALF_CYCLES = 1316
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [MESSAGE_LENGTH-1:0] data_in,
  input  logic                      data_valid_in,
  output logic                      ready_out,
  output logic                      signal_out,
  output logic                      envelope_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [2:0]                state_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(BIT_CYCLES, ONE_SPACE_CYCLES),
                                     max2(LEAD_MARK_CYCLES, LEAD_SPACE_CYCLES)),
                                max2(GAP_CYCLES, CARRIER_HALF_CYCLES));
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam int BW = $clog2(MESSAGE_LENGTH + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] ONE_LAST   = CW'(ONE_SPACE_CYCLES - 1);
  localparam logic [CW-1:0] LMARK_LAST = CW'(LEAD_MARK_CYCLES - 1);
  localparam logic [CW-1:0] LSPC_LAST  = CW'(LEAD_SPACE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  state_t                    state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [MESSAGE_LENGTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]             bit_cnt, bit_next;
  logic                      env_next, sig_next, ready_next, done_next;

  // Next-state, duration counter and shift register update
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    shift_next = shift_reg;
    bit_next   = bit_cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (data_valid_in) begin
          shift_next = data_in;
          bit_next   = BW'(MESSAGE_LENGTH);
          state_next = LEAD_MARK;
        end
      end
      LEAD_MARK: if (cnt == LMARK_LAST) begin
        state_next = LEAD_SPACE;
        cnt_next   = '0;
      end
      LEAD_SPACE: if (cnt == LSPC_LAST) begin
        state_next = BIT_MARK;
        cnt_next   = '0;
      end
      BIT_MARK: if (cnt == BIT_LAST) begin
        state_next = BIT_SPACE;
        cnt_next   = '0;
      end
      BIT_SPACE: if (cnt == (shift_reg[0] ? ONE_LAST : BIT_LAST)) begin
        shift_next = shift_reg >> 1;
        bit_next   = bit_cnt - BW'(1);
        state_next = (bit_cnt != BW'(1)) ? BIT_MARK : STOP_MARK;
        cnt_next   = '0;
      end
      STOP_MARK: if (cnt == BIT_LAST) begin
        state_next = GAP;
        cnt_next   = '0;
      end
      GAP: if (cnt == GAP_LAST) begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values are decoded from the next state so they can be registered
  always_comb begin
    env_next   = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                 (state_next == STOP_MARK);
    ready_next = (state_next == IDLE);
    done_next  = (state == GAP) && (state_next == IDLE);
  end

`ifdef IR_CARRIER_EN
  localparam int KW = $clog2(2 * CARRIER_HALF_CYCLES) + 1;
  localparam logic [KW-1:0] CAR_LAST = KW'(2 * CARRIER_HALF_CYCLES - 1);
  localparam logic [KW-1:0] CAR_HALF = KW'(CARRIER_HALF_CYCLES);

  logic [KW-1:0] car_cnt, car_next;

  // Carrier phase restarts on every mark entry so each mark begins LED-on
  always_comb begin
    car_next = car_cnt + KW'(1);
    if ((env_next && (state_next != state)) || (car_cnt == CAR_LAST)) begin
      car_next = '0;
    end
    sig_next = env_next && (car_next < CAR_HALF);
  end

  // Carrier phase register
  always_ff @(posedge clk_in) begin
    if (rst_in) car_cnt <= '0;
    else        car_cnt <= car_next;
  end
`else
  // Raw envelope drives the LED directly
  always_comb begin
    sig_next = env_next;
  end
`endif

  // State, datapath and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      ready_out    <= 1'b1;
      busy_out     <= 1'b0;
      envelope_out <= 1'b0;
      signal_out   <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      shift_reg    <= shift_next;
      bit_cnt      <= bit_next;
      ready_out    <= ready_next;
      busy_out     <= !ready_next;
      envelope_out <= env_next;
      signal_out   <= sig_next;
      done_out     <= done_next;
    end
  end

  assign state_out = state;

endmodule

// File: doc/ir_encoder.md
Name: ir_encoder

Overview:
IR transmitter counterpart to the receive-side ir_decoder. Accepts one MESSAGE_LENGTH-bit code per valid/ready handshake and serialises it as a pulse-distance frame: leader, data bits LSB first, stop mark, inter-frame gap. During marks the output is gated by a carrier so it can drive the IR LED on a PMOD pin. Sits on clk_100_passthrough in the transmitter top level, fed by the enigma encoder's data_valid_out/data_out.

Parameters:
MESSAGE_LENGTH, 5, data bits per frame
BIT_CYCLES, 56250, unit mark length and "0" space length (562.5 us at 100 MHz)
ONE_SPACE_CYCLES, 168750, space length for a "1" bit
LEAD_MARK_CYCLES, 900000, leader mark length
LEAD_SPACE_CYCLES, 450000, leader space length
GAP_CYCLES, 2000000, idle guard after the stop mark; ready_out stays low throughout
CARRIER_HALF_CYCLES, 1316, carrier half-period (~38 kHz)

Ports:
clk_in  input  1  system clock, 100 MHz
rst_in  input  1  synchronous active-high reset
data_in  input  MESSAGE_LENGTH  code to send
data_valid_in  input  1  code present on data_in
ready_out  output  1  high in IDLE only; transfer occurs when data_valid_in && ready_out
signal_out  output  1  to IR LED driver; 1 = LED on
envelope_out  output  1  unmodulated mark envelope (1 during any mark)
busy_out  output  1  equals !ready_out
done_out  output  1  one-cycle pulse on return to IDLE
state_out  output  3  current FSM state encoding, for debug

Behaviour:
- Clock is clk_in only; reset is synchronous and active-high (rst_in). Reset values: ready_out=1, busy_out=0, signal_out=0, envelope_out=0, done_out=0, state_out=IDLE(0). All counters and the shift register clear.
- FSM states and encodings: IDLE=0, LEAD_MARK=1, LEAD_SPACE=2, BIT_MARK=3, BIT_SPACE=4, STOP_MARK=5, GAP=6.
- Capture: on the edge where data_valid_in && ready_out (cycle T), latch data_in into the shift register and load the bit counter with MESSAGE_LENGTH.
  - From T+1: state=LEAD_MARK, ready_out=0.
  - data_in and data_valid_in are ignored while busy; no queueing.
- Each timed state lasts exactly its parameter count of cycles, then advances on the following edge:
  - LEAD_MARK (LEAD_MARK_CYCLES) -> LEAD_SPACE (LEAD_SPACE_CYCLES) -> BIT_MARK.
  - BIT_MARK (BIT_CYCLES) -> BIT_SPACE. BIT_SPACE length is BIT_CYCLES when shift reg LSB=0, ONE_SPACE_CYCLES when LSB=1.
  - At the end of BIT_SPACE: shift right, decrement the bit count. Go to BIT_MARK if the count is nonzero, else STOP_MARK (BIT_CYCLES).
  - STOP_MARK -> GAP (GAP_CYCLES) -> IDLE.
- Duration counter width: $clog2 of the largest cycle parameter, plus 1 bit. Counter restarts at 0 on every state entry.
- envelope_out=1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK.
- signal_out = envelope_out AND carrier. The carrier counter restarts at each mark entry:
  - high for the first CARRIER_HALF_CYCLES cycles, then low for CARRIER_HALF_CYCLES, repeating.
  - So every mark begins with the LED on.
- done_out is high for the single cycle in which the state is first IDLE after GAP, coinciding with ready_out rising. A new capture is allowed in that same cycle.
- Total busy time for a frame = LEAD_MARK + LEAD_SPACE + (MESSAGE_LENGTH+1)*BIT_CYCLES + zeros*BIT_CYCLES + ones*ONE_SPACE_CYCLES + GAP cycles.
- Reset mid-frame: on the next edge all outputs return to reset values and the frame is abandoned; no done_out pulse.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
IR_CARRIER_EN.
- Defined: signal_out is carrier-gated as described.
- Undefined: signal_out = envelope_out (raw envelope, LED held on for the whole mark). Carrier counter logic is removed. Used for direct wiring to the decoder's signal_in in simulation and loopback.
- envelope_out is identical in both builds.

Test Plan:
Common bench params: MESSAGE_LENGTH=5, BIT=4, ONE_SPACE=12, LEAD_MARK=16, LEAD_SPACE=8, GAP=10, CARRIER_HALF=2.
- Send 5'b00001 at cycle T -> ready_out low from T+1 to T+86. envelope_out sequence: 16 high, 8 low, then bit0 mark 4 / space 12, bits 1-4 mark 4 / space 4 each, stop 4 high, gap 10 low. ready_out and done_out high at T+87; done_out low at T+88.
- Send 5'b10110 and sample the envelope space widths -> space widths 4,12,12,4,12 (LSB first). Busy time 16+8+24+3*12+2*4+10 = 102 cycles.
- data_valid_in asserted with 5'b11111 during BIT_SPACE of the frame in progress -> current frame unaltered; no second frame follows; ready_out=1 after GAP.
- rst_in pulsed in LEAD_SPACE -> next edge: state_out=0, signal_out=0, envelope_out=0, ready_out=1, done_out never pulses. A following send of 5'b00001 matches scenario 1 timing exactly.
- IR_CARRIER_EN defined -> during the 16-cycle leader, signal_out pattern is 1100 repeated 4 times; each 4-cycle bit mark shows 1100. IR_CARRIER_EN undefined -> signal_out equals envelope_out on every cycle.
- Loopback: undefined IR_CARRIER_EN, envelope inverted into ir_decoder (MESSAGE_LENGTH=5) with matched timings, codes 0, 13, 25, 31 sent back to back -> decoder new_code_out pulses 4 times, code_out 0, 13, 25, 31 in order, error_out=0.
